// File: rtl/asip_video_pkg.sv
// asip_video_pkg: canvas geometry and fill-engine state shared by the pixel write path.
package asip_video_pkg;
    localparam int ImageWidth  = 320;
    localparam int ImageHeight = 240;
    localparam int ColorBits   = 3;
    localparam int XBits       = 9;
    localparam int YBits       = 8;
    localparam logic [XBits-1:0] XLimit = XBits'(ImageWidth);
    localparam logic [YBits-1:0] YLimit = YBits'(ImageHeight);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fill_state_t;
endpackage

// File: rtl/rect_fill_sequencer.sv
// rect_fill_sequencer: validates a rectangle, then offers its pixels row by row to the arbiter.
module rect_fill_sequencer
    import asip_video_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [XBits-1:0]     x0,
    input  logic [XBits-1:0]     x1,
    input  logic [YBits-1:0]     y0,
    input  logic [YBits-1:0]     y1,
    input  logic [ColorBits-1:0] color,
    input  logic                 abort,
    input  logic                 grant,
    output logic                 valid,
    output logic [XBits-1:0]     px_x,
    output logic [YBits-1:0]     px_y,
    output logic [ColorBits-1:0] px_color,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    fill_state_t          state_q;
    logic [XBits-1:0]     x0_q, x1_q, cx_q;
    logic [YBits-1:0]     y1_q, cy_q;
    logic [ColorBits-1:0] color_q;
    logic                 done_q, err_q;
    logic                 start_ok, last;

    assign start_ok = x0 <= x1 && y0 <= y1 && x1 < XLimit && y1 < YLimit;
    assign last     = cx_q == x1_q && cy_q == y1_q;
    assign valid    = state_q == RUN && !abort;
    assign px_x     = cx_q;
    assign px_y     = cy_q;
    assign px_color = color_q;
    // done_q trails the DONE state so fill_done lands one cycle after the last write strobe
    assign busy     = state_q != IDLE || done_q;
    assign done     = done_q;
    assign error    = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x0_q    <= '0;
            x1_q    <= '0;
            cx_q    <= '0;
            y1_q    <= '0;
            cy_q    <= '0;
            color_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    if (start_ok) begin
                        x0_q    <= x0;
                        x1_q    <= x1;
                        y1_q    <= y1;
                        cx_q    <= x0;
                        cy_q    <= y0;
                        color_q <= color;
                        state_q <= RUN;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                RUN: if (abort) begin
                    state_q <= IDLE;
                end else if (grant) begin
                    if (last) begin
                        state_q <= DONE;
                    end else if (cx_q < x1_q) begin
                        cx_q <= cx_q + 1'b1;
                    end else begin
                        cx_q <= x0_q;
                        cy_q <= cy_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: shares the frame memory write port between CPU pixel stores
// and the rectangle-fill engine with round-robin on contention.
module pixel_write_arbiter
    import asip_video_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic [XBits-1:0]     cpu_x,
    input  logic [YBits-1:0]     cpu_y,
    input  logic [ColorBits-1:0] cpu_color,
    output logic                 cpu_ack,
    output logic                 cpu_err,
    input  logic                 fill_start,
    input  logic [XBits-1:0]     fill_x0,
    input  logic [XBits-1:0]     fill_x1,
    input  logic [YBits-1:0]     fill_y0,
    input  logic [YBits-1:0]     fill_y1,
    input  logic [ColorBits-1:0] fill_color,
    input  logic                 fill_abort,
    output logic                 fill_busy,
    output logic                 fill_done,
    output logic                 fill_error,
    output logic [XBits-1:0]     XWrite,
    output logic [YBits-1:0]     YWrite,
    output logic [ColorBits-1:0] writeValueMemory,
    output logic                 mem_we
);
    logic                 fill_valid, cpu_elig, gnt_cpu, gnt_fill, cpu_in;
    logic [XBits-1:0]     fill_px_x, x_q, x_d;
    logic [YBits-1:0]     fill_px_y, y_q, y_d;
    logic [ColorBits-1:0] fill_px_c, c_q, c_d;
    logic                 we_q, we_d, ack_q, ack_d, err_q, err_d, last_fill_q, last_fill_d;

    rect_fill_sequencer u_seq (
        .clk      (clk),
        .reset    (reset),
        .start    (fill_start),
        .x0       (fill_x0),
        .x1       (fill_x1),
        .y0       (fill_y0),
        .y1       (fill_y1),
        .color    (fill_color),
        .abort    (fill_abort),
        .grant    (gnt_fill),
        .valid    (fill_valid),
        .px_x     (fill_px_x),
        .px_y     (fill_px_y),
        .px_color (fill_px_c),
        .busy     (fill_busy),
        .done     (fill_done),
        .error    (fill_error)
    );

    // a request still held during its own ack cycle must not be granted twice
    always_comb begin
        cpu_elig    = cpu_req && !ack_q;
        gnt_cpu     = cpu_elig && (!fill_valid || last_fill_q);
        gnt_fill    = fill_valid && !gnt_cpu;
        cpu_in      = cpu_x < XLimit && cpu_y < YLimit;
        we_d        = gnt_cpu ? cpu_in : gnt_fill;
        ack_d       = gnt_cpu;
        err_d       = gnt_cpu && !cpu_in;
        x_d         = gnt_cpu ? cpu_x : gnt_fill ? fill_px_x : x_q;
        y_d         = gnt_cpu ? cpu_y : gnt_fill ? fill_px_y : y_q;
        c_d         = gnt_cpu ? cpu_color : gnt_fill ? fill_px_c : c_q;
        last_fill_d = gnt_cpu ? 1'b0 : gnt_fill ? 1'b1 : last_fill_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q        <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            c_q         <= '0;
            last_fill_q <= 1'b1;
        end else begin
            we_q        <= we_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            x_q         <= x_d;
            y_q         <= y_d;
            c_q         <= c_d;
            last_fill_q <= last_fill_d;
        end
    end

    assign mem_we           = we_q;
    assign cpu_ack          = ack_q;
    assign cpu_err          = err_q;
    assign XWrite           = x_q;
    assign YWrite           = y_q;
    assign writeValueMemory = c_q;
endmodule
